// File: rtl/board_text_streamer_if.sv
// Byte stream from board_text_streamer toward a UART-style sink.
// The master drives the byte and its valid; the slave drives ready.
interface board_text_streamer_if;
  logic [7:0] char_out;
  logic       char_valid;
  logic       char_ready;

  modport master (output char_out, output char_valid, input char_ready);
  modport slave  (input char_out, input char_valid, output char_ready);
endinterface

// File: rtl/board_text_streamer.sv
// Snapshots a GRID x GRID tile board plus score, converts each value to decimal with a serial
// double-dabble, then streams the ASCII frame byte by byte. Option macro: BTS_ZERO_BLANK_EN.
module board_text_streamer #(
  parameter int unsigned GRID         = 4,
  parameter int unsigned TILE_W       = 20,
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SCORE_W      = 21,
  parameter int unsigned SCORE_DIGITS = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [GRID*GRID*TILE_W-1:0]   board,
  input  logic [SCORE_W-1:0]            score,
  board_text_streamer_if.master         tx,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned NT       = GRID * GRID;
  localparam int unsigned NBITS    = NT * TILE_W + SCORE_W;
  localparam int unsigned FW       = DIGITS + 3;
  localparam int unsigned W        = GRID * FW + 1;
  localparam int unsigned LINE_LEN = W + 2;
  localparam int unsigned TRL_LEN  = 11 + SCORE_DIGITS;
  localparam int unsigned TLINE    = 4 * GRID + 1;
  localparam int unsigned TDIG     = (TILE_W * 3 + 9) / 10 + 1;
  localparam int unsigned SDIG     = (SCORE_W * 3 + 9) / 10 + 1;
  localparam int unsigned MD       = (DIGITS > SCORE_DIGITS) ? DIGITS : SCORE_DIGITS;
  localparam int unsigned AD0      = (TDIG > SDIG) ? TDIG : SDIG;
  localparam int unsigned AD       = (AD0 > MD) ? AD0 : MD;
  localparam int unsigned MDW      = 4 * MD;
  localparam int unsigned MAXW     = (TILE_W > SCORE_W) ? TILE_W : SCORE_W;
  localparam int unsigned BIT_W    = $clog2(MAXW + 1);
  localparam int unsigned IDX_W    = $clog2(NT + 1);
  localparam int unsigned TI_W     = $clog2(NT);
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned LN_W     = 8;
  localparam logic [55:0] SCORE_TXT = "score: ";
`ifdef BTS_ZERO_BLANK_EN
  localparam bit ZERO_BLANK = 1'b1;
`else
  localparam bit ZERO_BLANK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;

  state_t               state;
  logic [NBITS-1:0]     sh;
  logic [4*AD-1:0]      acc, acc_adj, acc_nxt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [IDX_W-1:0]     val_idx;
  logic [4*DIGITS-1:0]  tile_bcd [NT];
  logic [NT-1:0]        tile_ovf;
  logic [4*SCORE_DIGITS-1:0] score_bcd;
  logic                 score_ovf;
  logic [LN_W-1:0]      line_q, nline;
  logic [CNT_W-1:0]     col_q, off_q, tcol_q, ncol, noff, ntcol;
  logic [7:0]           char_out_q, char_nxt;
  logic                 char_valid_q;
  logic                 is_score_c, last_bit_c, eol_c, last_c;
  int unsigned          ci, oi;
  logic [TI_W-1:0]      tsel;

  assign tx.char_out   = char_out_q;
  assign tx.char_valid = char_valid_q;

  // One field digit; idx 0 is the least significant digit of the field.
  function automatic logic [7:0] digit_char(input logic [MDW-1:0] bcd, input logic ovf,
                                            input int unsigned idx, input logic keep_last);
    logic [7:0] ch;
    ch = {4'h3, bcd[4*idx +: 4]};
    if (ZERO_BLANK && ((bcd >> (4 * idx)) == '0) && !(keep_last && idx == 0)) ch = 8'h20;
    if (ovf) ch = 8'h2A;
    return ch;
  endfunction

  // Double-dabble step on the shared accumulator, MSB of the snapshot shifted in.
  always_comb begin : dabble
    acc_adj = acc;
    for (int i = 0; i < int'(AD); i++) begin
      if (acc_adj[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_adj[4*i +: 4] + 4'd3;
    end
    acc_nxt    = {acc_adj[4*AD-2:0], sh[NBITS-1]};
    is_score_c = (val_idx == IDX_W'(NT));
    last_bit_c = is_score_c ? (bit_cnt == BIT_W'(SCORE_W - 1)) : (bit_cnt == BIT_W'(TILE_W - 1));
  end

  // Frame position of the byte following the one currently presented.
  always_comb begin : pos_next
    eol_c  = (line_q == LN_W'(TLINE)) ? (col_q == CNT_W'(TRL_LEN - 1))
                                      : (col_q == CNT_W'(LINE_LEN - 1));
    nline  = line_q;
    ncol   = col_q + CNT_W'(1);
    noff   = off_q + CNT_W'(1);
    ntcol  = tcol_q;
    last_c = 1'b0;
    if (eol_c) begin
      nline  = line_q + LN_W'(1);
      ncol   = '0;
      noff   = '0;
      ntcol  = '0;
      last_c = (line_q == LN_W'(TLINE));
    end else if (off_q == CNT_W'(FW - 1)) begin
      noff  = '0;
      ntcol = tcol_q + CNT_W'(1);
    end
  end

  // ASCII byte at the next position; line index TLINE is the score trailer.
  always_comb begin : char_gen
    ci       = 32'(ncol);
    oi       = 32'(noff);
    tsel     = TI_W'(32'(nline >> 2) * GRID + 32'(ntcol));
    char_nxt = 8'h20;
    if (nline == LN_W'(TLINE)) begin
      if (ci == 0)                          char_nxt = 8'h0D;
      else if (ci == 1)                     char_nxt = 8'h0A;
      else if (ci < 9)                      char_nxt = SCORE_TXT[8*(8-ci) +: 8];
      else if (ci < 9 + SCORE_DIGITS)
        char_nxt = digit_char(MDW'(score_bcd), score_ovf, SCORE_DIGITS + 8 - ci, 1'b1);
      else if (ci == 9 + SCORE_DIGITS)      char_nxt = 8'h0D;
      else                                  char_nxt = 8'h0A;
    end else if (ci == W) begin
      char_nxt = 8'h0D;
    end else if (ci == W + 1) begin
      char_nxt = 8'h0A;
    end else begin
      case (nline[1:0])
        2'd0: char_nxt = 8'h2D;
        2'd2: begin
          if (oi == 0) char_nxt = 8'h7C;
          else if (oi >= 2 && oi <= DIGITS + 1)
            char_nxt = digit_char(MDW'(tile_bcd[tsel]), tile_ovf[tsel], DIGITS + 1 - oi, 1'b0);
        end
        default: char_nxt = (oi == 0) ? 8'h7C : 8'h20;
      endcase
    end
  end

  always_ff @(posedge clk) begin : fsm
    if (rst) begin
      state        <= IDLE;
      char_out_q   <= '0;
      char_valid_q <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          for (int i = 0; i < int'(NT); i++)
            sh[NBITS-1-i*TILE_W -: TILE_W] <= board[i*TILE_W +: TILE_W];
          sh[SCORE_W-1:0] <= score;
          acc     <= '0;
          bit_cnt <= '0;
          val_idx <= '0;
          busy    <= 1'b1;
          state   <= CONV;
        end
        CONV: begin
          sh <= sh << 1;
          if (last_bit_c) begin
            acc     <= '0;
            bit_cnt <= '0;
            val_idx <= val_idx + IDX_W'(1);
            if (is_score_c) begin
              score_bcd    <= acc_nxt[4*SCORE_DIGITS-1:0];
              score_ovf    <= (acc_nxt >> (4 * SCORE_DIGITS)) != '0;
              line_q       <= '0;
              col_q        <= '0;
              off_q        <= '0;
              tcol_q       <= '0;
              char_out_q   <= 8'h2D;
              char_valid_q <= 1'b1;
              state        <= EMIT;
            end else begin
              tile_bcd[val_idx[TI_W-1:0]] <= acc_nxt[4*DIGITS-1:0];
              tile_ovf[val_idx[TI_W-1:0]] <= (acc_nxt >> (4 * DIGITS)) != '0;
            end
          end else begin
            acc     <= acc_nxt;
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
        EMIT: if (tx.char_ready) begin
          if (last_c) begin
            char_valid_q <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b1;
            state        <= IDLE;
          end else begin
            line_q     <= nline;
            col_q      <= ncol;
            off_q      <= noff;
            tcol_q     <= ntcol;
            char_out_q <= char_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_text_streamer.sv
// Self-checking bench for board_text_streamer: frames are rebuilt from decimal strings and
// compared byte for byte, with handshake, latency, abort and reset checks.
module tb_board_text_streamer;
  localparam int G = 4, TW = 20, D = 4, SW = 21, SD = 7;
  localparam int NT = G * G;
  localparam int NBITS = NT * TW + SW;
  localparam int NBYTES = 545;
`ifdef BTS_ZERO_BLANK_EN
  localparam logic [63:0] T1_L2 = "|      |", T1_S0 = "score:  ", T1_S1 = "     0\r\n";
  localparam logic [63:0] T2_L14 = "   4 |\r\n";
`else
  localparam logic [63:0] T1_L2 = "| 0000 |", T1_S0 = "score: 0", T1_S1 = "000000\r\n";
  localparam logic [63:0] T2_L14 = "0004 |\r\n";
`endif

  logic clk = 1'b0;
  logic rst, start, busy, done;
  logic [NT*TW-1:0] board;
  logic [SW-1:0] score;

  board_text_streamer_if tx();

  board_text_streamer #(.GRID(G), .TILE_W(TW), .DIGITS(D), .SCORE_W(SW), .SCORE_DIGITS(SD)) dut (
    .clk(clk), .rst(rst), .start(start), .board(board), .score(score),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [7:0] exp_q[$], got_q[$];
  int unsigned tiles_m[NT];
  int unsigned score_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic string field(input int unsigned v, input int d, input bit is_score);
    string s;
    longint unsigned lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    if (longint'(v) >= lim) begin
      s = "";
      repeat (d) s = {s, "*"};
      return s;
    end
    s = $sformatf("%0d", v);
`ifdef BTS_ZERO_BLANK_EN
    if (v == 0 && !is_score) s = "";
    while (s.len() < d) s = {" ", s};
`else
    while (s.len() < d) s = {"0", s};
`endif
    return s;
  endfunction

  function automatic string dash_line(input int w);
    string s = "";
    repeat (w) s = {s, "-"};
    return {s, "\r\n"};
  endfunction

  function automatic string blank_line(input int w, input int fw);
    string s = "";
    for (int c = 0; c < w; c++) s = {s, (c % fw == 0) ? "|" : " "};
    return {s, "\r\n"};
  endfunction

  function automatic void build_expected();
    string f = "", ln;
    int w = G * (D + 3) + 1;
    for (int r = 0; r < G; r++) begin
      f = {f, dash_line(w), blank_line(w, D + 3)};
      ln = "";
      for (int c = 0; c < G; c++) ln = {ln, "| ", field(tiles_m[r*G+c], D, 1'b0), " "};
      f = {f, ln, "|\r\n", blank_line(w, D + 3)};
    end
    f = {f, dash_line(w), "\r\nscore: ", field(score_m, SD, 1'b1), "\r\n"};
    exp_q.delete();
    for (int i = 0; i < f.len(); i++) exp_q.push_back(f[i]);
  endfunction

  function automatic logic [63:0] pack8(input int off);
    logic [63:0] r = '0;
    if (off + 8 > got_q.size()) return '0;
    for (int i = 0; i < 8; i++) r = {r[55:0], got_q[off+i]};
    return r;
  endfunction

  task automatic load_board();
    for (int i = 0; i < NT; i++) board[i*TW +: TW] = TW'(tiles_m[i]);
    score = SW'(score_m);
  endtask

  task automatic randomize_model();
    for (int i = 0; i < NT; i++) begin
      case ($urandom_range(0, 3))
        0: tiles_m[i] = 0;
        1: tiles_m[i] = 32'd1 << $urandom_range(1, 13);
        2: tiles_m[i] = $urandom_range(0, 9999);
        default: tiles_m[i] = $urandom_range(0, (1 << TW) - 1);
      endcase
    end
    score_m = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, (1 << SW) - 1);
  endtask

  task automatic run_frame(input string tag, input int ready_pct, input bit disturb);
    int lat = 0, cyc = 0, stab = 0, nmis = 0, first = -1, extra = 0;
    bit prev_stall = 1'b0, rdy, poked = 1'b0;
    logic [7:0] prev_c = '0;
    build_expected();
    load_board();
    got_q.delete();
    tx.char_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    if (disturb) begin
      for (int i = 0; i < NT; i++) board[i*TW +: TW] = TW'($urandom);
      score = SW'($urandom);
    end
    while (tx.char_valid !== 1'b1 && lat < 2000) begin
      tick();
      lat++;
    end
    chk({tag, "_conv_latency"}, 64'(lat), 64'(NBITS));
    while (done !== 1'b1 && cyc < 8000) begin
      if (prev_stall && !(tx.char_valid === 1'b1 && tx.char_out === prev_c)) stab++;
      rdy = ($urandom_range(0, 99) < ready_pct);
      tx.char_ready = rdy;
      prev_stall = tx.char_valid && !rdy;
      prev_c = tx.char_out;
      if (tx.char_valid && rdy) got_q.push_back(tx.char_out);
      start = disturb && !poked && got_q.size() == 100;
      if (start) poked = 1'b1;
      tick();
      cyc++;
    end
    start = 1'b0;
    tx.char_ready = 1'b1;
    chk({tag, "_done_seen"}, 64'(done), 64'd1);
    chk({tag, "_valid_at_done"}, 64'(tx.char_valid), 64'd0);
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    if (ready_pct == 100) chk({tag, "_emit_cycles"}, 64'(cyc), 64'(NBYTES));
    repeat (4) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    chk({tag, "_quiet_after_done"}, 64'(extra), 64'd0);
    chk({tag, "_stable_on_stall"}, 64'(stab), 64'd0);
    chk({tag, "_byte_count"}, 64'(got_q.size()), 64'(NBYTES));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        nmis++;
        if (first < 0) first = i;
      end
    end
    chk($sformatf("%s_bytes_first_bad_at_%0d", tag, first), 64'(nmis), 64'd0);
  endtask

  initial begin
    int n, cyc, extra;
    rst = 1'b1;
    start = 1'b0;
    board = '0;
    score = '0;
    tx.char_ready = 1'b0;
    repeat (3) tick();
    chk("reset_char_out", 64'(tx.char_out), 64'd0);
    chk("reset_valid", 64'(tx.char_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    rst = 1'b0;
    tick();

    // all-zero board and score
    foreach (tiles_m[i]) tiles_m[i] = 0;
    score_m = 0;
    run_frame("t1", 100, 1'b0);
    chk("t1_line0_head", pack8(0), "--------");
    chk("t1_line0_tail", pack8(23), "------\r\n");
    chk("t1_line2_head", pack8(62), T1_L2);
    chk("t1_score_a", pack8(NBYTES - 16), T1_S0);
    chk("t1_score_b", pack8(NBYTES - 8), T1_S1);

    // corner tiles and a full-width score
    foreach (tiles_m[i]) tiles_m[i] = 0;
    tiles_m[0] = 2048;
    tiles_m[15] = 4;
    score_m = 1234567;
    run_frame("t2", 100, 1'b0);
    chk("t2_line2_head", pack8(62), "| 2048 |");
    chk("t2_line14_tail", pack8(457), T2_L14);
    chk("t2_score_a", pack8(NBYTES - 16), "score: 1");
    chk("t2_score_b", pack8(NBYTES - 8), "234567\r\n");

    // overflowing tile and maximal score
    foreach (tiles_m[i]) tiles_m[i] = 0;
    tiles_m[6] = 12345;
    score_m = (1 << SW) - 1;
    run_frame("t3", 100, 1'b0);
    chk("t3_ovf_field", pack8(200), "| **** |");
    chk("t3_score_a", pack8(NBYTES - 16), "score: 2");
    chk("t3_score_b", pack8(NBYTES - 8), "097151\r\n");

    // random boards under backpressure, inputs disturbed mid-frame
    for (int k = 0; k < 3; k++) begin
      randomize_model();
      run_frame($sformatf("t4_%0d", k), 50, 1'b1);
    end

    // reset beats a simultaneous start
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", 64'(busy), 64'd0);
    tick();
    chk("rst_start_busy_later", 64'(busy), 64'd0);

    // abort after 200 accepted bytes, then a clean frame
    randomize_model();
    load_board();
    tx.char_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    cyc = 0;
    while (n < 200 && cyc < 3000) begin
      if (tx.char_valid === 1'b1) n++;
      tick();
      cyc++;
    end
    chk("t5_reached_byte_200", 64'(n), 64'd200);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_abort_valid", 64'(tx.char_valid), 64'd0);
    chk("t5_abort_busy", 64'(busy), 64'd0);
    extra = 0;
    repeat (6) begin
      if (done === 1'b1) extra++;
      tick();
    end
    chk("t5_no_done_after_abort", 64'(extra), 64'd0);
    randomize_model();
    run_frame("t5_after_abort", 100, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
